// File: rtl/mw_stall_if.sv
// Handshake and control bundle between the M/W pipeline logic and the stall sequencer.
// master = pipeline/memory side, slave = sequencer.
interface mw_stall_if #(
  parameter int unsigned CNT_W = 32
);
  logic             MemReadM;
  logic             MemWriteM;
  logic             syscallM;
  logic             mem_ack;
  logic             sys_done;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             BubbleW;
  logic             mem_req;
  logic             sys_start;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output MemReadM, MemWriteM, syscallM, mem_ack, sys_done,
    input  StallF, StallD, StallE, StallM, BubbleW, mem_req, sys_start,
           mem_timeout, stall_cycles
  );

  modport slave (
    input  MemReadM, MemWriteM, syscallM, mem_ack, sys_done,
    output StallF, StallD, StallE, StallM, BubbleW, mem_req, sys_start,
           mem_timeout, stall_cycles
  );
endinterface

// File: rtl/mw_stall_ctrl.sv
// Memory/writeback stall sequencer: freezes F/D/E/M and bubbles W during
// variable-latency data-memory accesses and external syscall service.
module mw_stall_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input logic        clk,
  input logic        rst_n,
  mw_stall_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    MEM_WAIT  = 3'd1,
    SYS_START = 3'd2,
    SYS_WAIT  = 3'd3,
    ERROR     = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_op;
  logic             stall;
  logic             mem_req;
  logic             sys_start;

  assign mem_op = bus.MemReadM | bus.MemWriteM;

  // NOTE: synchronous reset only; clk is the sole event in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so every register sees pre-edge values.
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == MEM_WAIT && state_nxt == ERROR)
        timeout_q <= 1'b1;
      if (stall && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_op) begin
          if (!bus.mem_ack) begin
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = 8'd1;
          end
        end else if (bus.syscallM) begin
          state_nxt = SYS_START;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT_C) begin
          state_nxt    = ERROR;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      SYS_START: state_nxt = SYS_WAIT;
      SYS_WAIT:  if (bus.sys_done) state_nxt = RUN;
      ERROR:     state_nxt = ERROR;
      default:   state_nxt = RUN;
    endcase
  end

  // A memory op has priority over a syscall in the same M slot; the syscall
  // is seen again in RUN once the access releases.
  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    sys_start = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_op) begin
          mem_req = 1'b1;
          stall   = ~bus.mem_ack;
        end else if (bus.syscallM) begin
          stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        stall   = ~bus.mem_ack;
      end
      SYS_START: begin
        stall     = 1'b1;
        sys_start = 1'b1;
      end
      SYS_WAIT: stall = ~bus.sys_done;
      ERROR:    stall = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  // W only ever gets a bubble while M is held, so the two share one term.
  assign bus.StallF       = stall;
  assign bus.StallD       = stall;
  assign bus.StallE       = stall;
  assign bus.StallM       = stall;
  assign bus.BubbleW      = stall;
  assign bus.mem_req      = mem_req;
  assign bus.sys_start    = sys_start;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cycles = cnt_q;

endmodule
